fetch_sequencer: RTL

//  Fetch-side controller for the halfword realign buffer. Generates word-aligned

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: issues word-aligned instruction requests, pairs the
// in-order responses with their addresses and feeds the halfword realign buffer.
module fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [31:0]           instr_rdata_i,
  output logic                  rb_clear_o,
  output logic                  rb_read_offset_o,
  output logic                  rb_write_en_o,
  output logic [31:0]           rb_instr_o,
  output logic [ADDR_WIDTH-1:0] rb_addr_o,
  input  logic                  rb_full_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_CLEAR, ST_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_outstanding, r_discard, r_sk_cnt, w_out_nxt;
  logic                  r_target_b1;
  logic                  r_after_rst;

  logic [ADDR_WIDTH-1:0] r_aq_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         r_aq_wr, r_aq_rd;
  logic [31:0]           r_sk_data [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] r_sk_addr [MAX_OUTSTANDING];
  logic [PW-1:0]         r_sk_wr, r_sk_rd;

  logic                  w_run, w_gnt, w_rv, w_keep, w_sk_empty, w_wr_ok;
  logic                  w_direct, w_sk_pop, w_sk_push;
  logic [SW-1:0]         w_inflight;
  logic [ADDR_WIDTH-1:0] w_aq_head;
  logic                  w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign w_unused   = redirect_addr_i[0];
  assign w_run      = (r_state == ST_RUN);
  assign w_inflight = SW'(r_outstanding) + SW'(r_sk_cnt);
  assign w_gnt      = instr_req_o & instr_gnt_i;
  // Responses with nothing outstanding (stale after reset) are never counted.
  assign w_rv       = instr_rvalid_i & (r_outstanding != '0);
  assign w_keep     = w_rv & ~redirect_i & (r_discard == '0);
  assign w_sk_empty = (r_sk_cnt == '0);
  assign w_wr_ok    = w_run & ~redirect_i & ~rb_full_i;
  assign w_direct   = w_keep & w_sk_empty & w_wr_ok;
  assign w_sk_pop   = ~w_sk_empty & w_wr_ok;
  assign w_sk_push  = w_keep & ~w_direct;
  assign w_aq_head  = r_aq_mem[r_aq_rd];
  assign w_out_nxt  = r_outstanding + CW'(w_gnt) - CW'(w_rv);

  assign instr_req_o      = w_run & ~redirect_i & (w_inflight < SW'(MAX_OUTSTANDING));
  assign instr_addr_o     = r_pc;
  assign rb_write_en_o    = w_direct | w_sk_pop;
  assign rb_instr_o       = w_sk_pop ? r_sk_data[r_sk_rd] : instr_rdata_i;
  assign rb_addr_o        = w_sk_pop ? r_sk_addr[r_sk_rd] : w_aq_head;
  assign rb_clear_o       = ~rst & (r_state != ST_RUN);
  assign rb_read_offset_o = ~rst & ((r_state == ST_BOOT)  ? BOOT_ADDR[1] :
                                    (r_state == ST_CLEAR) ? r_target_b1  : 1'b0);

  // Next-state logic; a redirect in any state restarts the clear.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_CLEAR: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
    if (redirect_i) w_state_nxt = ST_CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= {BOOT_ADDR[ADDR_WIDTH-1:2], 2'b00};
      r_outstanding <= '0;
      r_discard     <= '0;
      r_target_b1   <= 1'b0;
      r_after_rst   <= 1'b1;
      r_aq_wr       <= '0;
      r_aq_rd       <= '0;
      r_sk_wr       <= '0;
      r_sk_rd       <= '0;
      r_sk_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      if (w_gnt) begin
        r_after_rst <= 1'b0;
        r_aq_wr     <= ptr_inc(r_aq_wr);
      end
      if (w_rv) r_aq_rd <= ptr_inc(r_aq_rd);
      if (redirect_i) begin
        r_pc        <= {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
        r_target_b1 <= redirect_addr_i[1];
        r_discard   <= w_out_nxt;
        r_sk_wr     <= '0;
        r_sk_rd     <= '0;
        r_sk_cnt    <= '0;
      end else begin
        if (w_gnt) r_pc <= r_pc + ADDR_WIDTH'(4);
        if (w_rv && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_sk_push) r_sk_wr <= ptr_inc(r_sk_wr);
        if (w_sk_pop)  r_sk_rd <= ptr_inc(r_sk_rd);
        r_sk_cnt <= r_sk_cnt + CW'(w_sk_push) - CW'(w_sk_pop);
      end
    end
  end

  // Address queue and skid storage need no reset; pointers qualify contents.
  always_ff @(posedge clk) begin
    if (w_gnt) r_aq_mem[r_aq_wr] <= r_pc;
    if (w_sk_push && !redirect_i) begin
      r_sk_data[r_sk_wr] <= instr_rdata_i;
      r_sk_addr[r_sk_wr] <= w_aq_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(instr_rvalid_i && (r_outstanding == '0)) || r_after_rst)
        else $error("fetch_sequencer: rvalid with no outstanding request");
    end
  end

endmodule
